// File: rtl/mux_sel_pkg.sv
// ---------------------------------------------------------------------------
// mux_sel_pkg : FSM state type, default timing constants, counter width helper
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_sel_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_GRANTED = 2'd2
  } state_t;

  localparam int DWELL_DEFAULT  = 4;
  localparam int SETTLE_DEFAULT = 2;

  // Smallest width able to hold value (at least one bit).
  function automatic int cnt_width(input int value);
    return (value < 2) ? 1 : $clog2(value + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_dncnt.sv
// ---------------------------------------------------------------------------
// mux_sel_dncnt : loadable down-counter that saturates at zero
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_sel_dncnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

endmodule

`default_nettype wire

// File: rtl/mux_select_ctrl.sv
// ---------------------------------------------------------------------------
// mux_select_ctrl : 2:1 mux select/grant controller with dwell and settle time
// Optional Lock input enabled by MUX_SELECT_CTRL_LOCK_EN. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_select_ctrl
  import mux_sel_pkg::*;
#(
  parameter int DWELL  = DWELL_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
`ifdef MUX_SELECT_CTRL_LOCK_EN
  input  logic Lock,
`endif
  input  logic Req0,
  input  logic Req1,
  output logic Select,
  output logic _Select,
  output logic Grant0,
  output logic Grant1,
  output logic Busy
);

  localparam int DW = cnt_width(DWELL);
  localparam int SW = cnt_width(SETTLE);

  state_t          state, next_state;
  logic            sel_q, sel_n_q, next_sel;
  logic            grant0_q, grant1_q, busy_q;
  logic            last_granted;
  logic            do_switch, update_last;
  logic            own_req, oth_req, want_other;
  logic            dwell_ok, settle_last, lock;
  logic [DW-1:0]   dwell_cnt;
  logic [SW-1:0]   settle_cnt;

`ifdef MUX_SELECT_CTRL_LOCK_EN
  assign lock = Lock;
`else
  assign lock = 1'b0;
`endif

  mux_sel_dncnt #(.WIDTH(DW)) u_dwell (
    .clk      (Clock),
    .rst      (Reset),
    .load     (do_switch),
    .load_val (DW'(DWELL)),
    .count    (dwell_cnt)
  );

  mux_sel_dncnt #(.WIDTH(SW)) u_settle (
    .clk      (Clock),
    .rst      (Reset),
    .load     (do_switch),
    .load_val (SW'(SETTLE)),
    .count    (settle_cnt)
  );

  // Counter reaching zero on this edge marks DWELL full cycles since the last switch.
  assign dwell_ok    = (dwell_cnt <= DW'(1));
  assign settle_last = (settle_cnt == SW'(1));

  assign own_req    = sel_q ? Req1 : Req0;
  assign oth_req    = sel_q ? Req0 : Req1;
  // With both requesting, the side that was not served last takes priority.
  assign want_other = oth_req && (!own_req || (last_granted == sel_q));

  always_comb begin
    next_state  = state;
    next_sel    = sel_q;
    do_switch   = 1'b0;
    update_last = 1'b0;
    case (state)
      ST_HOLD: begin
        if (want_other) begin
          if (dwell_ok && !lock) begin
            do_switch  = 1'b1;
            next_sel   = ~sel_q;
            next_state = ST_SETTLE;
          end
        end else if (own_req) begin
          next_state = ST_GRANTED;
        end
      end
      ST_SETTLE: begin
        if (!own_req)
          next_state = ST_HOLD;
        else if (settle_last)
          next_state = ST_GRANTED;
      end
      ST_GRANTED: begin
        if (!own_req) begin
          next_state  = ST_HOLD;
          update_last = 1'b1;
        end
      end
      default: next_state = ST_HOLD;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_HOLD;
      sel_q        <= 1'b0;
      sel_n_q      <= 1'b1;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      busy_q       <= 1'b0;
      last_granted <= 1'b1;
    end else begin
      state    <= next_state;
      sel_q    <= next_sel;
      sel_n_q  <= ~next_sel;
      grant0_q <= (next_state == ST_GRANTED) && !next_sel;
      grant1_q <= (next_state == ST_GRANTED) &&  next_sel;
      busy_q   <= (next_state != ST_HOLD);
      if (update_last)
        last_granted <= sel_q;
    end
  end

  assign Select  = sel_q;
  assign _Select = sel_n_q;
  assign Grant0  = grant0_q;
  assign Grant1  = grant1_q;
  assign Busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_select_ctrl : scoreboard bench, directed vectors then random stress
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_select_ctrl;

  logic clk, rst, req0, req1, lock;
  logic sel, sel_n, g0, g1, busy;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q [$];
  int         step_q [$];

  mux_select_ctrl #(.DWELL(4), .SETTLE(2)) dut (
    .Clock   (clk),
    .Reset   (rst),
`ifdef MUX_SELECT_CTRL_LOCK_EN
    .Lock    (lock),
`endif
    .Req0    (req0),
    .Req1    (req1),
    .Select  (sel),
    ._Select (sel_n),
    .Grant0  (g0),
    .Grant1  (g1),
    .Busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {rst, req0, req1, Select, _Select, Grant0, Grant1, Busy} after each edge
  localparam int NVEC = 37;
  logic [7:0] vec [0:NVEC-1] = '{
    8'b100_01000, 8'b100_01000, 8'b000_01000, 8'b010_01101, 8'b010_01101,
    8'b000_01000, 8'b011_10001, 8'b011_10001, 8'b011_10011, 8'b011_10011,
    8'b010_10000, 8'b010_01001, 8'b010_01001, 8'b010_01101, 8'b000_01000,
    8'b001_10001, 8'b000_10000, 8'b010_10000, 8'b010_10000, 8'b010_01001,
    8'b010_01001, 8'b010_01101, 8'b000_01000, 8'b001_10001, 8'b001_10001,
    8'b001_10011, 8'b101_01000, 8'b101_01000, 8'b001_10001, 8'b001_10001,
    8'b001_10011, 8'b000_10000, 8'b011_01001, 8'b011_01001, 8'b011_01101,
    8'b010_01101, 8'b000_01000
  };

  // Monitor: scoreboard compare plus per-cycle invariants.
  initial begin
    logic       prev_sel;
    logic       have_prev;
    logic [4:0] got, want;
    int         stp;
    have_prev = 1'b0;
    prev_sel  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      got = {sel, sel_n, g0, g1, busy};
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        stp  = step_q.pop_front();
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL vec step=%0d got {sel,_sel,g0,g1,busy}=%b want=%b", stp, got, want);
        end
      end
      checks++;
      if (sel === sel_n) begin
        failures++;
        $display("FAIL sel_pair got=%b%b want complementary", sel, sel_n);
      end
      checks++;
      if (g0 && g1) begin
        failures++;
        $display("FAIL grant_excl got g0=%b g1=%b want not both", g0, g1);
      end
      if (have_prev) begin
        checks++;
        if ((sel != prev_sel) && (g0 || g1)) begin
          failures++;
          $display("FAIL grant_on_switch got sel %b->%b with g0=%b g1=%b", prev_sel, sel, g0, g1);
        end
      end
      prev_sel  = sel;
      have_prev = 1'b1;
    end
  end

  initial begin
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    lock = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst  = vec[i][7];
      req0 = vec[i][6];
      req1 = vec[i][5];
      exp_q.push_back(vec[i][4:0]);
      step_q.push_back(i);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end

    // Random stress: requests held for several cycles, occasional reset and lock.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 15) == 0) lock = ~lock;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_select_ctrl.md
MUX_SELECT_CTRL -- requirements
Module: mux_select_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4: minimum cycles between side switches, range 0..255.
REQ-002 The block SHALL have parameter SETTLE, default 2: cycles from a Select change to Grant, range 1..15.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port Req0, input, 1 bit: request from the In0 source, held until served.
REQ-006 The block SHALL have port Req1, input, 1 bit: request from the In1 source, held until served.
REQ-007 The block SHALL have port Select, output, 1 bit: drives the downstream 2:1 mux; 1 selects In1.
REQ-008 The block SHALL have port _Select, output, 1 bit: complement of Select; 1 selects In0.
REQ-009 The block SHALL have port Grant0, output, 1 bit: In0 owns the mux and the path has settled.
REQ-010 The block SHALL have port Grant1, output, 1 bit: In1 owns the mux and the path has settled.
REQ-011 The block SHALL have port Busy, output, 1 bit: high in the SETTLE or GRANTED state.

Function
REQ-012 All outputs SHALL be driven directly from flops; there SHALL be no combinational input-to-output path.
REQ-013 {Select,_Select} SHALL always be 01 or 10 and SHALL never be 00 or 11, including in the first cycle after Reset.
REQ-014 The FSM SHALL have states HOLD (selection stable, no grant), SETTLE (counting after a switch) and GRANTED.
REQ-015 HOLD, current side requested, no higher-priority contender: the FSM SHALL enter GRANTED and assert that Grant on the first edge that samples the Req high.
REQ-016 HOLD, only the other side requested, dwell counter zero: Select/_Select SHALL toggle on that edge, the FSM SHALL enter SETTLE, and the settle counter SHALL load SETTLE.
REQ-017 HOLD, other side requested, dwell counter nonzero: the FSM SHALL stay in HOLD until the counter reaches zero.
REQ-018 HOLD, both Req high: the side not equal to last_granted SHALL win; if that is the current side apply REQ-015, otherwise REQ-016/017.
REQ-019 SETTLE: Grant SHALL assert exactly SETTLE edges after the Select change if the requesting Req is still high.
REQ-020 Req withdrawn during SETTLE: the FSM SHALL return to HOLD with no Grant, and Select SHALL keep its new value.
REQ-021 GRANTED: Grant SHALL stay high while the owning Req is high and SHALL fall on the first edge that samples Req low.
REQ-022 On leaving GRANTED: last_granted SHALL be updated and the FSM SHALL enter HOLD.
REQ-023 The dwell counter SHALL load DWELL on every side switch and decrement to zero, saturating; DWELL=0 SHALL permit back-to-back switches.
REQ-024 Grant0 and Grant1 SHALL never be high together.
REQ-025 A Grant SHALL never be high in the cycle where Select changes.
REQ-026 Counter widths SHALL be the minimum that holds the parameter value, with no wrap-around.

Reset
REQ-027 While Reset is sampled high: Select=0, _Select=1, Grant0=Grant1=Busy=0, state=HOLD, last_granted=1, dwell=0, settle=0.
REQ-028 Reset mid-SETTLE or mid-GRANTED SHALL abort immediately to the REQ-027 values, with no Grant glitch on the reset edge.

Configuration
REQ-029 With macro MUX_SELECT_CTRL_LOCK_EN defined, input Lock (1 bit) SHALL exist; Lock high SHALL inhibit switches, but same-side grants SHALL proceed.
REQ-030 With MUX_SELECT_CTRL_LOCK_EN defined, Lock SHALL have no effect in SETTLE or GRANTED.
REQ-031 Without MUX_SELECT_CTRL_LOCK_EN, the Lock port and its logic SHALL be absent, and behaviour SHALL equal Lock tied low.

Structure
REQ-032 Package mux_sel_pkg SHALL hold the FSM state enum and the default DWELL/SETTLE constants.
REQ-033 A single sub-module mux_sel_dncnt (loadable, saturating down-counter) SHALL be instantiated twice, once for dwell and once for settle.

Verification
REQ-034 Release Reset, hold Req0 high from cycle 2 -> {Select,_Select}=01 throughout; Grant0 high 1 cycle after Req0 sampled.
REQ-035 SETTLE=2, DWELL=0, Req1 raised in HOLD -> Select=1 next edge, Grant1 high 2 edges later, Busy high in between.
REQ-036 DWELL=4, serve In1 then raise Req0 at once -> switch delayed until 4 edges after the previous switch.
REQ-037 Req0 and Req1 both high after In0 was last served -> In1 granted first; when Req1 drops, In0 is served next.
REQ-038 Reset asserted while Grant1 high -> next edge Grant1=0, Select=0, _Select=1; Req1 drop during SETTLE -> HOLD, no Grant.
REQ-039 Random Req stress, 10k cycles, with LOCK_EN both defined and undefined -> assertions for REQ-013, REQ-024 and REQ-025 never fire.
